// File: rtl/font_pkg.sv
// Shared font definitions: glyph geometry, font RAM address type and the
// loader state encoding. Used by the loader, the renderer and the font RAM.
// Optional feature macro: FONT_LOADER_CHECKSUM_EN adds the CHK state.
package font_pkg;

    localparam int CHAR_BITS      = 9;
    localparam int ROW_BITS       = 3;
    localparam int ROWS_PER_GLYPH = 8;
    localparam int ADDR_BITS      = CHAR_BITS + ROW_BITS;

    localparam logic [7:0] FONT_SYNC_BYTE = 8'hA5;

    typedef logic [CHAR_BITS-1:0] char_code_t;
    typedef logic [ROW_BITS-1:0]  row_idx_t;
    typedef logic [ADDR_BITS-1:0] font_addr_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CODE_HI,
        ST_CODE_LO,
        ST_ROWS,
`ifdef FONT_LOADER_CHECKSUM_EN
        ST_CHK,
`endif
        ST_COMMIT
    } loader_state_t;

    // Renderer addressing: {char_code, line}
    function automatic font_addr_t make_font_addr(input char_code_t code, input row_idx_t row);
        return {code, row};
    endfunction

endpackage

// File: rtl/glyph_row_buf.sv
// 8x8 glyph staging buffer: one write port filled while rows stream in,
// one asynchronous read port walked by the commit counter.
module glyph_row_buf
    import font_pkg::*;
(
    input  logic       clk,
    input  logic       wr_en,
    input  row_idx_t   wr_row,
    input  logic [7:0] wr_data,
    input  row_idx_t   rd_row,
    output logic [7:0] rd_data
);

    logic [7:0] mem [ROWS_PER_GLYPH];

    // Store an incoming row bitmap; contents need no reset, every frame overwrites all rows
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_row] <= wr_data;
        end
    end

    assign rd_data = mem[rd_row];

endmodule

// File: rtl/font_loader.sv
// Streaming glyph writer: parses framed bytes (A5, code_hi, code_lo, 8 rows
// [, checksum]) and commits the buffered glyph as eight font RAM writes.
// Optional feature macro: FONT_LOADER_CHECKSUM_EN (trailing XOR checksum byte).
module font_loader
    import font_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             wr_en,
    output font_addr_t       wr_addr,
    output logic [7:0]       wr_data,
    output logic             busy,
    output logic             done,
    output logic             err
);

    loader_state_t state;
    loader_state_t state_next;
    logic          err_next;
    logic          xfer;
    row_idx_t      row_idx;
    logic [3:0]    commit_idx;   // 0..7 issue writes, 8 = settle cycle before IDLE
    char_code_t    char_code;
    logic [7:0]    rd_data;
    logic          buf_wr;
`ifdef FONT_LOADER_CHECKSUM_EN
    logic [7:0]    csum;
`endif

    assign in_ready = !reset && (state != ST_COMMIT);
    assign xfer     = in_valid && in_ready;
    assign busy     = (state != ST_IDLE);
    assign buf_wr   = xfer && (state == ST_ROWS);

    glyph_row_buf u_buf (
        .clk     (clk),
        .wr_en   (buf_wr),
        .wr_row  (row_idx),
        .wr_data (in_data),
        .rd_row  (commit_idx[ROW_BITS-1:0]),
        .rd_data (rd_data)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Frame parser next-state and rejection decode
    always_comb begin
        state_next = state;
        err_next   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (xfer && in_data == FONT_SYNC_BYTE) begin
                    state_next = ST_CODE_HI;
                end
            end
            ST_CODE_HI: begin
                if (xfer) begin
                    if (in_data[7:1] != 7'd0) begin
                        state_next = ST_IDLE;
                        err_next   = 1'b1;
                    end else begin
                        state_next = ST_CODE_LO;
                    end
                end
            end
            ST_CODE_LO: begin
                if (xfer) begin
                    state_next = ST_ROWS;
                end
            end
            ST_ROWS: begin
                if (xfer && row_idx == 3'd7) begin
`ifdef FONT_LOADER_CHECKSUM_EN
                    state_next = ST_CHK;
`else
                    state_next = ST_COMMIT;
`endif
                end
            end
`ifdef FONT_LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (xfer) begin
                    if (in_data == csum) begin
                        state_next = ST_COMMIT;
                    end else begin
                        state_next = ST_IDLE;
                        err_next   = 1'b1;
                    end
                end
            end
`endif
            ST_COMMIT: begin
                if (commit_idx == 4'd8) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Counters and registered write-port / status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            row_idx    <= '0;
            commit_idx <= '0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            err   <= err_next;
            if (state == ST_CODE_LO && xfer) begin
                row_idx <= '0;
            end
            if (buf_wr) begin
                row_idx <= row_idx + 3'd1;
            end
            if (state == ST_COMMIT) begin
                if (commit_idx != 4'd8) begin
                    wr_en      <= 1'b1;
                    wr_addr    <= make_font_addr(char_code, commit_idx[ROW_BITS-1:0]);
                    wr_data    <= rd_data;
                    done       <= (commit_idx == 4'd7);
                    commit_idx <= commit_idx + 4'd1;
                end else begin
                    commit_idx <= '0;
                end
            end
        end
    end

    // Capture the character code (and running checksum) as header bytes arrive
    always_ff @(posedge clk) begin
        if (xfer && state == ST_CODE_HI) begin
            char_code[CHAR_BITS-1] <= in_data[0];
        end
        if (xfer && state == ST_CODE_LO) begin
            char_code[7:0] <= in_data;
        end
`ifdef FONT_LOADER_CHECKSUM_EN
        if (xfer && state == ST_CODE_HI) begin
            csum <= in_data;
        end
        if (xfer && (state == ST_CODE_LO || state == ST_ROWS)) begin
            csum <= csum ^ in_data;
        end
`endif
    end

endmodule

// File: doc/font_loader.md
# font_loader

Streaming glyph writer for the character generator's font memory. It accepts framed bytes on a valid/ready byte stream from a UART bridge or boot sequencer. Each frame carries one glyph: a 9-bit character code and eight row bitmaps. The block buffers the glyph, then commits it as eight write cycles to the 512-glyph × 8-row font RAM that the text renderer reads as {char_code, line[2:0]}.

## Interface
- SYNC_BYTE, 8'hA5: frame start marker.
- CHAR_BITS, 9: character code width (512 glyphs).
- ROW_BITS, 3: row index width (8 rows per glyph); wr_addr width = CHAR_BITS+ROW_BITS.
- clk  in  1: single clock; all logic rising-edge.
- reset  in  1: synchronous, active-high.
- in_data  in  8: stream byte.
- in_valid  in  1: in_data valid.
- in_ready  out  1: block accepts the byte; a transfer occurs when in_valid && in_ready at a clk edge.
- wr_en  out  1: font RAM write strobe.
- wr_addr  out  CHAR_BITS+ROW_BITS: {char_code, row}.
- wr_data  out  8: row bitmap, MSB = leftmost pixel.
- busy  out  1: frame in progress (any state but IDLE).
- done  out  1: one-cycle pulse, glyph committed.
- err  out  1: one-cycle pulse, frame rejected.

## Operation
- States: IDLE, CODE_HI, CODE_LO, ROWS, CHK (only with the macro), COMMIT.
- IDLE:
  - Bytes ≠ SYNC_BYTE are accepted and discarded.
  - SYNC_BYTE → CODE_HI.
- CODE_HI:
  - Byte bit0 = char_code[8].
  - Bits[7:1] ≠ 0 → err pulse, back to IDLE, nothing written.
  - Otherwise → CODE_LO.
- CODE_LO: byte = char_code[7:0] → ROWS with row counter 0.
- ROWS:
  - Each accepted byte stored in buffer[row] and the counter increments.
  - After row 7 → CHK if enabled, else COMMIT.
  - SYNC_BYTE inside a frame is ordinary data; there is no resync.
- COMMIT:
  - 8 consecutive cycles with wr_en=1 and wr_addr={char_code, k}, wr_data=buffer[k], for k=0..7.
  - Then → IDLE.
- in_ready:
  - 1 in every state except COMMIT.
  - Forced 0 while reset is high.
- The RAM is never written before the whole frame has been accepted (and checked, when enabled).

## Timing
- Reset values: wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, err=0, state=IDLE, counters 0.
- in_ready is 1 from the first cycle after reset deasserts.
- wr_en/wr_addr/wr_data/done/err are registered.
- Commit timing: final byte (row 7 or checksum) accepted at edge N → wr_en high in cycles N+1..N+8.
- done is high in cycle N+8, coincident with the row-7 write.
- in_ready returns to 1 in cycle N+9.
- err is high in the cycle after the offending byte is accepted; the state is already IDLE in that cycle.
- Backpressure: in_valid held during COMMIT is not consumed; the byte transfers at the first cycle of IDLE.
- Reset mid-frame or mid-commit: the next edge returns to IDLE with wr_en=0 and the buffer discarded. Writes already issued are not undone.
- Minimum frame: 11 accepted bytes (12 with checksum) plus 8 commit cycles.

## Configuration
- FONT_LOADER_CHECKSUM_EN defined:
  - The frame carries one extra byte after row 7, equal to XOR of code_hi, code_lo and rows 0..7.
  - Match → COMMIT.
  - Mismatch → err pulse, IDLE, no writes.
- Undefined: no checksum byte; COMMIT directly after row 7; the CHK state does not exist.

## Structure
- Shared package font_pkg:
  - CHAR_BITS, ROW_BITS, ROWS_PER_GLYPH=8, FONT_SYNC_BYTE=8'hA5.
  - Loader state enum typedef.
  - Font-address typedef, also used by the renderer and font RAM.
- One natural sub-module: glyph_row_buf, an 8×8 register file with a write port (ROWS) and a read port indexed by the commit counter.

## Test plan
- Glyph 'A':
  - Stream A5 00 41 18 24 42 7E 42 42 42 00 (+03 with checksum).
  - → writes 0x208..0x20F = 18,24,42,7E,42,42,42,00; done in the 8th write cycle.
- Max code:
  - A5 01 FF + 8 rows.
  - → writes at 0xFF8..0xFFF; busy high from the byte after A5 until done.
- Bad code_hi:
  - A5 02 ….
  - → err one cycle, no wr_en.
  - Following valid frame for char 0x020 writes 0x100..0x107.
- Leading garbage:
  - 00 FF 12 A5 00 30 + rows.
  - → only 0x180..0x187 written; garbage accepted with in_ready=1.
- Reset mid-frame:
  - Reset after the 4th row byte.
  - → no wr_en, busy=0 next cycle; next full frame commits correctly.
- Backpressure and checksum:
  - With macro, a wrong checksum byte → err, no writes.
  - With in_valid held high across COMMIT, the next A5 is accepted exactly at cycle N+9.
